// File: rtl/dma_prio_arbiter_n_if.sv
// Bus bundle between the DMA arbiter and its environment: request inputs,
// command bits, the HRQ/HLDA handshake and the DACK grant outputs.
interface dma_prio_arbiter_n_if #(
  parameter int NCH = 4
) ();
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0] DREQ;
  logic           HLDA;
  logic [NCH-1:0] mask;
  logic [NCH-1:0] sw_req;
  logic           rot_pri;
  logic           ctrl_dis;
  logic           xfer_done;
  logic           HRQ;
  logic [NCH-1:0] DACK;
  logic [CHW-1:0] active_ch;
  logic           grant_vld;
  logic           svc_abort;

  // slave: the arbiter itself; master: command regs / CPU / timing side
  modport slave (
    input  DREQ, HLDA, mask, sw_req, rot_pri, ctrl_dis, xfer_done,
    output HRQ, DACK, active_ch, grant_vld, svc_abort
  );

  modport master (
    output DREQ, HLDA, mask, sw_req, rot_pri, ctrl_dis, xfer_done,
    input  HRQ, DACK, active_ch, grant_vld, svc_abort
  );
endinterface

// File: rtl/dma_prio_arbiter_n.sv
// N-channel DMA request/priority arbiter: merges DREQ, sw_req and masks,
// runs the HRQ/HLDA handshake and grants one channel via DACK.
module dma_prio_arbiter_n #(
  parameter int NCH           = 4,
  parameter bit DREQ_ACT_HIGH = 1'b1,
  parameter bit DACK_ACT_HIGH = 1'b0
) (
  input logic                  CLK,
  input logic                  RESET,
  dma_prio_arbiter_n_if.slave  bus
);
  localparam int             CHW       = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [NCH-1:0] DACK_IDLE = {NCH{~DACK_ACT_HIGH}};
  localparam logic [NCH-1:0] ONE_HOT0  = {{(NCH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, REQ, SVC, REL} state_t;

  state_t         r_state, w_state;
  logic           r_hrq, w_hrq;
  logic [NCH-1:0] r_dack, w_dack;
  logic [CHW-1:0] r_active_ch, w_active_ch;
  logic           r_gvld, w_gvld;
  logic           r_abort, w_abort;
  logic [CHW-1:0] r_pri_ptr, w_pri_ptr;
  logic [CHW-1:0] w_win, w_base, w_next_ptr;
  logic [NCH-1:0] w_dreq, w_eff;
  logic           w_any;

  assign w_dreq = DREQ_ACT_HIGH ? bus.DREQ : ~bus.DREQ;
  assign w_eff  = (w_dreq & ~bus.mask) | bus.sw_req;
  assign w_any  = |w_eff;
  assign w_base = bus.rot_pri ? r_pri_ptr : '0;
  assign w_next_ptr = (r_active_ch == CHW'(NCH-1)) ? '0 : r_active_ch + 1'b1;

  // Circular scan starting at w_base; first set request wins.
  always_comb begin
    logic [CHW:0] w_idx;
    logic         w_found;
    w_win   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NCH; k++) begin
      w_idx = {1'b0, w_base} + (CHW+1)'(k);
      if (w_idx >= (CHW+1)'(NCH)) w_idx = w_idx - (CHW+1)'(NCH);
      if (!w_found && w_eff[w_idx[CHW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[CHW-1:0];
      end
    end
  end

  always_comb begin
    w_state     = r_state;
    w_hrq       = r_hrq;
    w_dack      = r_dack;
    w_active_ch = r_active_ch;
    w_gvld      = r_gvld;
    w_abort     = 1'b0;
    w_pri_ptr   = bus.rot_pri ? r_pri_ptr : '0;
    case (r_state)
      IDLE: begin
        if (!bus.ctrl_dis && w_any) begin
          w_hrq   = 1'b1;
          w_state = REQ;
        end
      end
      REQ: begin
        if (bus.ctrl_dis || !w_any) begin
          w_hrq   = 1'b0;
          w_state = IDLE;
        end else if (bus.HLDA) begin
          w_active_ch = w_win;
          w_dack      = DACK_IDLE ^ (ONE_HOT0 << w_win);
          w_gvld      = 1'b1;
          w_state     = SVC;
        end
      end
      SVC: begin
        // Completion wins over a simultaneous HLDA drop.
        if (bus.xfer_done) begin
          w_hrq   = 1'b0;
          w_dack  = DACK_IDLE;
          w_gvld  = 1'b0;
          w_state = REL;
          if (bus.rot_pri) w_pri_ptr = w_next_ptr;
        end else if (!bus.HLDA) begin
          w_hrq   = 1'b0;
          w_dack  = DACK_IDLE;
          w_gvld  = 1'b0;
          w_abort = 1'b1;
          w_state = REL;
        end
      end
      REL: begin
        w_hrq = 1'b0;
        if (!bus.HLDA) w_state = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_hrq       <= 1'b0;
      r_dack      <= DACK_IDLE;
      r_active_ch <= '0;
      r_gvld      <= 1'b0;
      r_abort     <= 1'b0;
      r_pri_ptr   <= '0;
    end else begin
      r_state     <= w_state;
      r_hrq       <= w_hrq;
      r_dack      <= w_dack;
      r_active_ch <= w_active_ch;
      r_gvld      <= w_gvld;
      r_abort     <= w_abort;
      r_pri_ptr   <= w_pri_ptr;
    end
  end

  assign bus.HRQ       = r_hrq;
  assign bus.DACK      = r_dack;
  assign bus.active_ch = r_active_ch;
  assign bus.grant_vld = r_gvld;
  assign bus.svc_abort = r_abort;
endmodule

// File: tb/tb_dma_prio_arbiter_n.sv
// Directed bench for dma_prio_arbiter_n: fixed priority/masks (A), rotation and
// abort on 8 channels (B), active-low DREQ/DACK with reset mid-service (C).
module tb_dma_prio_arbiter_n;
  logic CLK = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  dma_prio_arbiter_n_if #(.NCH(4)) ifa ();
  dma_prio_arbiter_n_if #(.NCH(8)) ifb ();
  dma_prio_arbiter_n_if #(.NCH(4)) ifc ();

  dma_prio_arbiter_n #(.NCH(4), .DREQ_ACT_HIGH(1'b1), .DACK_ACT_HIGH(1'b0))
    dut_a (.CLK(CLK), .RESET(rst_a), .bus(ifa.slave));
  dma_prio_arbiter_n #(.NCH(8), .DREQ_ACT_HIGH(1'b1), .DACK_ACT_HIGH(1'b1))
    dut_b (.CLK(CLK), .RESET(rst_b), .bus(ifb.slave));
  dma_prio_arbiter_n #(.NCH(4), .DREQ_ACT_HIGH(1'b0), .DACK_ACT_HIGH(1'b0))
    dut_c (.CLK(CLK), .RESET(rst_c), .bus(ifc.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    ifa.DREQ = '0; ifa.HLDA = 0; ifa.mask = '0; ifa.sw_req = '0;
    ifa.rot_pri = 0; ifa.ctrl_dis = 0; ifa.xfer_done = 0;
    ifb.DREQ = '0; ifb.HLDA = 0; ifb.mask = '0; ifb.sw_req = '0;
    ifb.rot_pri = 1; ifb.ctrl_dis = 0; ifb.xfer_done = 0;
    ifc.DREQ = '1; ifc.HLDA = 0; ifc.mask = '0; ifc.sw_req = '0;
    ifc.rot_pri = 0; ifc.ctrl_dis = 0; ifc.xfer_done = 0;
    tick; tick;
    rst_a = 0; rst_b = 0; rst_c = 0;

    // reset values
    chk("a_rst_hrq",  ifa.HRQ, 0);
    chk("a_rst_dack", ifa.DACK, 4'hF);
    chk("a_rst_gvld", ifa.grant_vld, 0);
    chk("a_rst_ach",  ifa.active_ch, 0);
    chk("a_rst_abrt", ifa.svc_abort, 0);
    chk("b_rst_dack", ifb.DACK, 8'h00);

    // fixed priority: 1010 -> ch1 then ch3
    ifa.DREQ = 4'b1010;
    tick; chk("a_hrq_up", ifa.HRQ, 1);
    chk("a_no_gnt_req", ifa.grant_vld, 0);
    ifa.HLDA = 1;
    tick; chk("a_gnt_ch1", ifa.active_ch, 1);
    chk("a_dack_ch1", ifa.DACK, 4'b1101);
    chk("a_gvld", ifa.grant_vld, 1);
    ifa.DREQ = 4'b0000;
    tick; chk("a_hold_ch1", ifa.active_ch, 1);
    chk("a_hold_dack", ifa.DACK, 4'b1101);
    ifa.xfer_done = 1;
    tick; ifa.xfer_done = 0;
    chk("a_done_hrq", ifa.HRQ, 0);
    chk("a_done_dack", ifa.DACK, 4'hF);
    chk("a_done_gvld", ifa.grant_vld, 0);
    ifa.DREQ = 4'b1000; ifa.HLDA = 0;
    tick; chk("a_rel_hrq_low", ifa.HRQ, 0);
    tick; chk("a_hrq2", ifa.HRQ, 1);
    ifa.HLDA = 1;
    tick; chk("a_gnt_ch3", ifa.active_ch, 3);
    chk("a_dack_ch3", ifa.DACK, 4'b0111);
    ifa.xfer_done = 1;
    tick; ifa.xfer_done = 0; ifa.HLDA = 0; ifa.DREQ = '0;
    tick;

    // mask vs software request
    ifa.mask = 4'b1111; ifa.DREQ = 4'b1111; ifa.sw_req = 4'b0100;
    tick; chk("a_sw_hrq", ifa.HRQ, 1);
    ifa.HLDA = 1;
    tick; chk("a_sw_ch2", ifa.active_ch, 2);
    chk("a_sw_dack", ifa.DACK, 4'b1011);
    ifa.xfer_done = 1;
    tick; ifa.xfer_done = 0; ifa.sw_req = '0; ifa.HLDA = 0;
    tick; tick; tick;
    chk("a_masked_no_hrq", ifa.HRQ, 0);
    chk("a_masked_dack", ifa.DACK, 4'hF);

    // withdrawal and disable while in REQ
    ifa.mask = '0; ifa.DREQ = 4'b0001;
    tick; chk("a_wd_hrq", ifa.HRQ, 1);
    ifa.DREQ = '0;
    tick; chk("a_wd_drop", ifa.HRQ, 0);
    chk("a_wd_dack", ifa.DACK, 4'hF);
    ifa.DREQ = 4'b0001;
    tick; chk("a_dis_hrq", ifa.HRQ, 1);
    ifa.ctrl_dis = 1;
    tick; chk("a_dis_drop", ifa.HRQ, 0);
    chk("a_dis_gvld", ifa.grant_vld, 0);
    tick; chk("a_dis_stay", ifa.HRQ, 0);
    ifa.ctrl_dis = 0; ifa.DREQ = '0;

    // rotating priority, 10 back-to-back services on 8 channels
    ifb.DREQ = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      tick; chk("b_rot_hrq", ifb.HRQ, 1);
      ifb.HLDA = 1;
      tick; chk($sformatf("b_rot_ch%0d", i), ifb.active_ch, i % 8);
      chk("b_rot_dack", ifb.DACK, 32'h1 << (i % 8));
      ifb.xfer_done = 1;
      tick; ifb.xfer_done = 0;
      chk("b_rot_rel", ifb.grant_vld, 0);
      ifb.HLDA = 0;
      tick;
    end
    chk("b_ptr_end", dut_b.r_pri_ptr, 2);

    // abort on ch3
    ifb.DREQ = 8'h08;
    tick; chk("b_ab_hrq", ifb.HRQ, 1);
    ifb.HLDA = 1;
    tick; chk("b_ab_ch3", ifb.active_ch, 3);
    ifb.HLDA = 0;
    tick; chk("b_ab_pulse", ifb.svc_abort, 1);
    chk("b_ab_dack", ifb.DACK, 8'h00);
    chk("b_ab_gvld", ifb.grant_vld, 0);
    chk("b_ab_hrq0", ifb.HRQ, 0);
    chk("b_ab_ptr", dut_b.r_pri_ptr, 2);
    tick; chk("b_ab_one_cyc", ifb.svc_abort, 0);

    // xfer_done and HLDA drop together on ch7: completion, pointer wraps
    ifb.DREQ = 8'h80;
    tick; chk("b_sc_hrq", ifb.HRQ, 1);
    ifb.HLDA = 1;
    tick; chk("b_sc_ch7", ifb.active_ch, 7);
    ifb.xfer_done = 1; ifb.HLDA = 0;
    tick; ifb.xfer_done = 0;
    chk("b_sc_noabort", ifb.svc_abort, 0);
    chk("b_sc_gvld", ifb.grant_vld, 0);
    chk("b_sc_ptr", dut_b.r_pri_ptr, 0);
    ifb.DREQ = '0;
    tick; chk("b_sc_noabort2", ifb.svc_abort, 0);

    // active-low DREQ/DACK, reset mid-service
    ifc.DREQ = 4'b0111;
    tick; chk("c_hrq", ifc.HRQ, 1);
    ifc.HLDA = 1;
    tick; chk("c_ch3", ifc.active_ch, 3);
    chk("c_dack3", ifc.DACK, 4'b0111);
    rst_c = 1;
    tick; rst_c = 0; ifc.HLDA = 0; ifc.DREQ = 4'b1111;
    chk("c_rst_dack", ifc.DACK, 4'hF);
    chk("c_rst_hrq", ifc.HRQ, 0);
    chk("c_rst_gvld", ifc.grant_vld, 0);
    chk("c_rst_abrt", ifc.svc_abort, 0);
    chk("c_rst_state", 32'(dut_c.r_state), 0);
    ifc.DREQ = 4'b1110;
    tick; chk("c_hrq2", ifc.HRQ, 1);
    ifc.HLDA = 1;
    tick; chk("c_ch0", ifc.active_ch, 0);
    chk("c_dack0", ifc.DACK, 4'b1110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
